// File: rtl/pixel_pair_serializer.sv
// Pixel-pair FIFO + serializer: HSYNC pairs in, one tagged pixel per valid/ready beat out (2 cycles HSYNC->m_valid).
// Holds output stable under back-pressure; drops pairs when full (sticky overflow). Define GRAY_OUT_EN for Y=(R+2G+B)>>2 grey output.
module pixel_pair_serializer #(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          VSYNC,
  input  logic                          HSYNC,
  input  logic [7:0]                    DATA_R0,
  input  logic [7:0]                    DATA_G0,
  input  logic [7:0]                    DATA_B0,
  input  logic [7:0]                    DATA_R1,
  input  logic [7:0]                    DATA_G1,
  input  logic [7:0]                    DATA_B1,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [23:0]                   m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_eof,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  typedef struct packed {
    logic [23:0] pix1;
    logic [23:0] pix0;
    logic        sof;
    logic        eol;
    logic        eof;
  } pair_t;

  typedef enum logic [1:0] {ST_IDLE, ST_PIX0, ST_PIX1} state_t;

  function automatic logic [23:0] conv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef GRAY_OUT_EN
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return {sum[9:2], sum[9:2], sum[9:2]};
`else
    return {r, g, b};
`endif
  endfunction

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_vsync_d;
  logic          r_ovf;
  logic          r_fd;
  pair_t         r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  pair_t         r_hold;
  state_t        r_state;

  state_t        w_state_nxt;
  logic          w_full, w_empty, w_push, w_pop, w_eol;
  pair_t         w_wr;

  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = HSYNC && !w_full;
  assign w_eol   = (r_col == CW'(PAIRS - 1));

  assign w_wr.pix0 = conv(DATA_R0, DATA_G0, DATA_B0);
  assign w_wr.pix1 = conv(DATA_R1, DATA_G1, DATA_B1);
  assign w_wr.sof  = (r_col == '0) && (r_row == '0);
  assign w_wr.eol  = w_eol;
  assign w_wr.eof  = w_eol && (r_row == RW'(HEIGHT - 1));

  // Position counters advance on every HSYNC, including dropped pairs, so tags stay aligned to the raster.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (VSYNC) begin
      r_col <= '0;
      r_row <= '0;
    end else if (HSYNC) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_vsync_d <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_vsync_d <= VSYNC;
      if (VSYNC && !r_vsync_d) r_ovf <= 1'b0;
      if (HSYNC && w_full)     r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push) r_mem[r_wptr] <= w_wr;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_hold <= r_mem[r_rptr];
      r_fd <= (r_state == ST_PIX1) && m_ready && r_hold.eof;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_sof       = 1'b0;
    m_eol       = 1'b0;
    m_eof       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_PIX0;
        end
      end
      ST_PIX0: begin
        m_valid = 1'b1;
        m_data  = r_hold.pix0;
        m_sof   = r_hold.sof;
        if (m_ready) w_state_nxt = ST_PIX1;
      end
      ST_PIX1: begin
        m_valid = 1'b1;
        m_data  = r_hold.pix1;
        m_eol   = r_hold.eol;
        m_eof   = r_hold.eof;
        // Refill straight from the FIFO so back-to-back pairs stream without a bubble.
        if (m_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_PIX0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign frame_done = r_fd;
  assign overflow   = r_ovf;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_pixel_pair_serializer.sv
// Directed bench for pixel_pair_serializer (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4) with a queue scoreboard and output monitor.
module tb_pixel_pair_serializer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        VSYNC = 1'b0;
  logic        HSYNC = 1'b0;
  logic [7:0]  DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0]  DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic        m_ready = 1'b0;
  logic        m_valid, m_sof, m_eol, m_eof, frame_done, overflow;
  logic [23:0] m_data;
  logic [2:0]  fifo_level;

  pixel_pair_serializer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 HCLK = ~HCLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [26:0] sb_q[$];
  logic [26:0] exp_beat;
  bit          fd_pend = 1'b0;
  int          tb_col = 0;
  int          tb_row = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [23:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef GRAY_OUT_EN
    logic [9:0] s;
    s = 10'(r) + 10'(g) + 10'(g) + 10'(b);
    return {s[9:2], s[9:2], s[9:2]};
`else
    return {r, g, b};
`endif
  endfunction

  // Drives one pair for one cycle; the expected beats carry tags from the bench's own raster position.
  task automatic send_pair(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                           input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1,
                           input bit keep);
    logic sof, eol, eof;
    sof = (tb_col == 0) && (tb_row == 0);
    eol = (tb_col == W / 2 - 1);
    eof = eol && (tb_row == H - 1);
    DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
    DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
    HSYNC = 1'b1;
    if (keep) begin
      sb_q.push_back({px(r0, g0, b0), sof, 1'b0, 1'b0});
      sb_q.push_back({px(r1, g1, b1), 1'b0, eol, eof});
    end
    if (eol) begin
      tb_col = 0;
      tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
    end else begin
      tb_col++;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic send_n(input int base, input int n, input int keep_n);
    @(posedge HCLK); #1;
    for (int i = 0; i < n; i++) begin
      send_pair(8'(16 * (base + i)), 8'(base + i + 1), 8'hA0,
                8'(16 * (base + i) + 8), 8'(base + i + 2), 8'h5B, i < keep_n);
    end
    HSYNC = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge HCLK);
    while (!m_valid && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check(name, 32'(m_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge HCLK);
  endtask

  task automatic vsync_pulse();
    @(posedge HCLK); #1 VSYNC = 1'b1;
    @(posedge HCLK); #1 VSYNC = 1'b0;
    tb_col = 0;
    tb_row = 0;
  endtask

  always @(negedge HCLK) begin
    if (HRESETn) begin
      check("frame_done", 32'(frame_done), 32'(fd_pend));
      fd_pend = 1'b0;
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL beat: got unexpected pixel %h, expected none", m_data);
        end else begin
          exp_beat = sb_q.pop_front();
          check("beat", 32'({m_data, m_sof, m_eol, m_eof}), 32'(exp_beat));
          if (exp_beat[0]) fd_pend = 1'b1;
        end
      end else if (!m_valid) begin
        check("tags_idle", 32'({m_sof, m_eol, m_eof}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge HCLK);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_flags", 32'({m_sof, m_eol, m_eof, frame_done, overflow}), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    repeat (5) begin
      @(negedge HCLK);
      check("idle_valid", 32'(m_valid), 32'd0);
    end

    // One full 4x2 frame, free-flowing consumer, with first-pixel latency
    m_ready = 1'b1;
    fork
      send_n(0, 4, 4);
      begin
        @(posedge HCLK); #1;
        @(negedge HCLK); check("lat_c0", 32'(m_valid), 32'd0);
        @(negedge HCLK); check("lat_c1", 32'(m_valid), 32'd0);
        @(negedge HCLK); check("lat_c2", 32'(m_valid), 32'd1);
      end
    join
    wait_drain("drain_frame");

    // Stall 10 cycles on the odd (eol) pixel of a line
    @(posedge HCLK); #1 m_ready = 1'b0;
    send_n(4, 2, 2);
    wait_valid("wait_stall");
    @(posedge HCLK); #1 m_ready = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 m_ready = 1'b0;
    repeat (10) begin
      @(negedge HCLK);
      check("stall_data", 32'(m_data), 32'(px(8'd88, 8'd7, 8'h5B)));
      check("stall_tags", 32'({m_valid, m_eol, m_eof}), 32'b110);
    end
    @(posedge HCLK); #1 m_ready = 1'b1;
    wait_drain("drain_stall");

    // Overflow: 6 pairs into 1 holding slot + 4 FIFO entries
    vsync_pulse();
    @(posedge HCLK); #1 m_ready = 1'b0;
    send_n(8, 6, 5);
    @(negedge HCLK);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_hold_valid", 32'(m_valid), 32'd1);
    @(posedge HCLK); #1 m_ready = 1'b1;
    wait_drain("drain_ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("drained_level", 32'(fifo_level), 32'd0);
    vsync_pulse();
    @(negedge HCLK);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Colour path: R=10,G=20,B=30
    @(posedge HCLK); #1;
    send_pair(8'd10, 8'd20, 8'd30, 8'd1, 8'd2, 8'd3, 1'b1);
    HSYNC = 1'b0;
    wait_valid("wait_colour");
`ifdef GRAY_OUT_EN
    check("colour_px", 32'(m_data), 32'h141414);
`else
    check("colour_px", 32'(m_data), 32'h0A141E);
`endif
    wait_drain("drain_colour");

    // Asynchronous reset mid-line, then a fresh frame must start with sof
    @(posedge HCLK); #1 m_ready = 1'b0;
    send_n(16, 2, 2);
    wait_valid("wait_prereset");
    #2 HRESETn = 1'b0;
    #1;
    check("arst_valid", 32'(m_valid), 32'd0);
    check("arst_data", 32'(m_data), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    sb_q.delete();
    fd_pend = 1'b0;
    tb_col = 0;
    tb_row = 0;
    @(posedge HCLK); #1 HRESETn = 1'b1;
    m_ready = 1'b1;
    send_n(20, 1, 1);
    wait_drain("drain_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
